// File: rtl/rgb565_line_packer.sv
// RGB888 -> RGB565 line packer: two pixels per 32-bit word with SOF/EOL/EOF tags, buffered in a FWFT FIFO.
// Optional macro PACKER_TEST_PATTERN_EN adds a test_mode input that substitutes eight vertical colour bars.
module rgb565_line_packer #(
  parameter int DISP_WIDTH = 640,
  parameter int DISP_HIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vsync,
  input  logic        data_in_valid,
  input  logic [23:0] data_in,
`ifdef PACKER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        overflow,
  output logic        frame_done
);

  localparam int CW = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
  localparam int RW = (DISP_HIGHT > 1) ? $clog2(DISP_HIGHT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(DISP_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DISP_HIGHT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_ACTIVE, ST_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [15:0]   r_hold;
  logic [34:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_frame_done;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [23:0]   w_pixel;
  logic [15:0]   w_p565;
  logic          w_unused_bits;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_sof;
  logic          w_eol;
  logic          w_eof;
  logic [34:0]   w_head;

  // A frame_vsync pixel is pixel 0 of the new frame, so geometry restarts combinationally.
  assign w_col = frame_vsync ? '0 : r_col;
  assign w_row = frame_vsync ? '0 : r_row;

`ifdef PACKER_TEST_PATTERN_EN
  localparam int BAR_W = (DISP_WIDTH >= 8) ? DISP_WIDTH / 8 : 1;
  logic [31:0] w_bar_idx;
  logic [23:0] w_bar_rgb;
  assign w_bar_idx = 32'(w_col) / 32'(BAR_W);

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      32'd0:   w_bar_rgb = 24'hFFFFFF;
      32'd1:   w_bar_rgb = 24'hFFFF00;
      32'd2:   w_bar_rgb = 24'h00FFFF;
      32'd3:   w_bar_rgb = 24'h00FF00;
      32'd4:   w_bar_rgb = 24'hFF00FF;
      32'd5:   w_bar_rgb = 24'hFF0000;
      32'd6:   w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_pixel = test_mode ? w_bar_rgb : data_in;
`else
  assign w_pixel = data_in;
`endif

  assign w_p565        = {w_pixel[23:19], w_pixel[15:10], w_pixel[7:3]};
  assign w_unused_bits = ^{w_pixel[18:16], w_pixel[9:8], w_pixel[2:0]};

  assign w_accept  = data_in_valid && (frame_vsync || (r_state == ST_ACTIVE));
  assign w_push    = w_accept && w_col[0];
  assign w_pop     = m_valid && m_ready;
  assign w_push_ok = w_push && ((r_count != FIFO_FULL) || w_pop);
  assign w_sof     = (w_row == '0) && (w_col == CW'(1));
  assign w_eol     = (w_col == COL_LAST);
  assign w_eof     = w_eol && (w_row == ROW_LAST);

  // Later assignments win: a pixel arriving with frame_vsync overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACTIVE;
      r_col   <= '0;
      r_row   <= '0;
      r_hold  <= '0;
    end else begin
      if (frame_vsync) begin
        r_state <= ST_ACTIVE;
        r_col   <= '0;
        r_row   <= '0;
        r_hold  <= '0;
      end
      if (w_accept) begin
        if (!w_col[0]) r_hold <= w_p565;
        if (w_col == COL_LAST) begin
          r_col <= '0;
          if (w_row == ROW_LAST) begin
            r_row   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_row <= w_row + 1'b1;
          end
        end else begin
          r_col <= w_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {w_eof, w_eol, w_sof, w_p565, r_hold};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (frame_vsync)             r_overflow <= 1'b0;
      else if (w_push && !w_push_ok) r_overflow <= 1'b1;
      r_frame_done <= w_pop && w_head[34];
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign m_valid    = (r_count != '0);
  assign m_data     = m_valid ? w_head[31:0] : 32'h0;
  assign m_sof      = m_valid && w_head[32];
  assign m_eol      = m_valid && w_head[33];
  assign m_eof      = m_valid && w_head[34];
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rgb565_line_packer.sv
// Scoreboard bench for rgb565_line_packer (8x2 frame, 4-deep FIFO); test-pattern section needs PACKER_TEST_PATTERN_EN.
module tb_rgb565_line_packer;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_vsync;
  logic        data_in_valid;
  logic [23:0] data_in;
  logic        m_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_sof, m_eol, m_eof;
  logic        overflow;
  logic        frame_done;
`ifdef PACKER_TEST_PATTERN_EN
  logic        test_mode;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } word_t;

  word_t       expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          mCol, mRow;
  bit          mDone, mOverflow, mFrameDone;
  logic [15:0] mHold;
  bit          checking = 0;
  int          wordsSeen = 0;
  int          doneSeen = 0;

  rgb565_line_packer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .frame_vsync(frame_vsync), .data_in_valid(data_in_valid),
    .data_in(data_in),
`ifdef PACKER_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .m_eof(m_eof), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  function automatic logic [23:0] barColour(input int col);
    logic [23:0] bars [8];
    int idx;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    idx = col / ((W >= 8) ? W / 8 : 1);
    if (idx > 7) idx = 7;
    return bars[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit vs, input bit vld, input logic [23:0] d, input bit rdy);
    @(posedge clk);
    #2;
    frame_vsync   = vs;
    data_in_valid = vld;
    data_in       = d;
    m_ready       = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) applyStimulus(1'b0, 1'b0, 24'h0, rdy);
  endtask

  // Reference model: pop first, so a push into a full FIFO succeeds when a pop happens the same edge.
  always @(posedge clk) begin
    word_t       w;
    logic [23:0] pix;
    if (rst) begin
      expQ.delete();
      mCol = 0; mRow = 0; mDone = 0; mHold = 16'h0; mOverflow = 0; mFrameDone = 0;
    end else begin
      mFrameDone = 0;
      if (m_ready && expQ.size() != 0) begin
        mFrameDone = expQ[0].eof;
        void'(expQ.pop_front());
      end
      if (frame_vsync) begin
        mCol = 0; mRow = 0; mDone = 0; mHold = 16'h0; mOverflow = 0;
      end
      if (data_in_valid && !mDone) begin
        pix = data_in;
`ifdef PACKER_TEST_PATTERN_EN
        if (test_mode) pix = barColour(mCol);
`endif
        if (mCol % 2 == 0) begin
          mHold = to565(pix);
        end else begin
          w.data = {to565(pix), mHold};
          w.sof  = (mRow == 0) && (mCol == 1);
          w.eol  = (mCol == W - 1);
          w.eof  = w.eol && (mRow == H - 1);
          if (expQ.size() < D) expQ.push_back(w);
          else mOverflow = 1;
        end
        mCol++;
        if (mCol == W) begin
          mCol = 0;
          mRow++;
          if (mRow == H) begin
            mRow = 0;
            mDone = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m_valid", 32'(m_valid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("m_data", m_data, expQ[0].data);
        checkOutput("flags", {29'h0, m_sof, m_eol, m_eof}, {29'h0, expQ[0].sof, expQ[0].eol, expQ[0].eof});
      end
      checkOutput("overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("frame_done", 32'(frame_done), 32'(mFrameDone));
      if (m_valid && m_ready) wordsSeen++;
      if (frame_done) doneSeen++;
    end
  end

  initial begin
    rst = 1'b1; frame_vsync = 1'b0; data_in_valid = 1'b0; data_in = 24'h0; m_ready = 1'b0;
`ifdef PACKER_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    @(posedge clk);
    #2;
    checking = 1;
    @(negedge clk);
    #1;
    checkOutput("reset_data", m_data, 32'h0);
    checkOutput("reset_flags", {26'h0, m_valid, m_sof, m_eol, m_eof, overflow, frame_done}, 32'h0);
    rst = 1'b0;

    $display("[TB] full frame, constant pixel, m_ready high");
    wordsSeen = 0; doneSeen = 0;
    applyStimulus(1'b1, 1'b1, 24'hFF8040, 1'b1);
    repeat (15) applyStimulus(1'b0, 1'b1, 24'hFF8040, 1'b1);
    idle(6, 1'b1);
    checkOutput("t1_words", 32'(wordsSeen), 32'd8);
    checkOutput("t1_frame_done_pulses", 32'(doneSeen), 32'd1);

    $display("[TB] pixel pair latency and hold under back-pressure");
    applyStimulus(1'b1, 1'b1, 24'h123456, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'hABCDEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t2_valid", 32'(m_valid), 32'd1);
    checkOutput("t2_data", m_data, {to565(24'hABCDEF), to565(24'h123456)});
    idle(3, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t2_data_held", m_data, {to565(24'hABCDEF), to565(24'h123456)});
    idle(3, 1'b1);

    $display("[TB] whole frame with m_ready low");
    for (int i = 0; i < 16; i++)
      applyStimulus(i == 0, 1'b1, {8'(i * 16), 8'(255 - i * 8), 8'(i * 3 + 5)}, 1'b0);
    idle(3, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t3_overflow_cleared", 32'(overflow), 32'd0);
    wordsSeen = 0;
    idle(8, 1'b1);
    checkOutput("t3_stored_words", 32'(wordsSeen), 32'd4);

    $display("[TB] push into full FIFO with simultaneous pop");
    for (int i = 0; i < 9; i++)
      applyStimulus(i == 0, 1'b1, 24'(32'h0A0B0C + i * 32'h111111), 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h5A5A5A, 1'b1);
    idle(2, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t4_no_overflow", 32'(overflow), 32'd0);
    wordsSeen = 0;
    idle(8, 1'b1);
    checkOutput("t4_count_stayed_full", 32'(wordsSeen), 32'd4);

    $display("[TB] excess pixels ignored, mid-line restart");
    wordsSeen = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus(i == 0, 1'b1, 24'($urandom), 1'b1);
    idle(4, 1'b1);
    checkOutput("t5_words", 32'(wordsSeen), 32'd8);
    for (int i = 0; i < 3; i++)
      applyStimulus(i == 0, 1'b1, 24'($urandom), 1'b1);
    for (int i = 0; i < 8; i++)
      applyStimulus(i == 0, 1'b1, 24'($urandom), 1'b1);
    idle(4, 1'b1);

`ifdef PACKER_TEST_PATTERN_EN
    $display("[TB] colour bar test pattern");
    test_mode = 1'b1;
    wordsSeen = 0;
    for (int i = 0; i < 16; i++)
      applyStimulus(i == 0, 1'b1, 24'($urandom), 1'b1);
    idle(4, 1'b1);
    checkOutput("t6_words", 32'(wordsSeen), 32'd8);
    test_mode = 1'b0;
`endif

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
